// File: rtl/pinpong_pkg.sv
// Shared encodings for the ping-pong match sequencer.
// State, side and default match constants.
package pinpong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_RALLY       = 3'd2,
    ST_POINT_PAUSE = 3'd3,
    ST_GAME_OVER   = 3'd4
  } state_t;

  localparam logic SIDE_SELF  = 1'b0;
  localparam logic SIDE_ENEMY = 1'b1;

  localparam int DEF_WIN_SCORE   = 11;
  localparam int DEF_PAUSE_TICKS = 4;

endpackage

// File: rtl/pinpong_score_unit.sv
// Score counters, win/deuce detect, service rotation
// and winner latch for one match.
import pinpong_pkg::*;

module pinpong_score_unit #(
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int SCORE_W    = 5,
  parameter int SERVE_SWAP = 2,
  parameter int DEUCE_EN   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               award,
  input  logic               side,
  output logic [SCORE_W-1:0] score_self,
  output logic [SCORE_W-1:0] score_enemy,
  output logic               server,
  output logic               winner,
  output logic               win
);

  localparam int RW = (SERVE_SWAP < 2) ? 1
                    : $clog2(SERVE_SWAP + 1);

  localparam logic [SCORE_W-1:0] MAX = '1;
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_M1 =
    SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W:0] TWO =
    (SCORE_W+1)'(2);
  localparam logic [RW-1:0] SWAP =
    RW'(SERVE_SWAP);

  logic [RW-1:0]      rot;
  logic [RW-1:0]      rot_inc;
  logic [SCORE_W-1:0] nx_self;
  logic [SCORE_W-1:0] nx_enemy;
  logic               deuce;

  function automatic logic win_of(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] ax;
    logic [SCORE_W:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    if (DEUCE_EN != 0)
      return (a >= WIN && ax >= bx + TWO) ||
             (b >= WIN && bx >= ax + TWO) ||
             a == MAX || b == MAX;
    else
      return a == WIN || b == WIN;
  endfunction

  assign win     = win_of(score_self, score_enemy);
  assign rot_inc = rot + 1'b1;
  assign deuce   = (DEUCE_EN != 0) &&
                   score_self  >= WIN_M1 &&
                   score_enemy >= WIN_M1;

  always_comb begin
    nx_self  = score_self;
    nx_enemy = score_enemy;
    if (award) begin
      if (side == SIDE_ENEMY) begin
        if (score_enemy != MAX)
          nx_enemy = score_enemy + 1'b1;
      end else begin
        if (score_self != MAX)
          nx_self = score_self + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      score_self  <= '0;
      score_enemy <= '0;
      server      <= SIDE_SELF;
      winner      <= SIDE_SELF;
      rot         <= '0;
    end else if (award) begin
      score_self  <= nx_self;
      score_enemy <= nx_enemy;
      if (deuce) begin
        server <= ~server;
        rot    <= '0;
      end else if (rot_inc == SWAP) begin
        server <= ~server;
        rot    <= '0;
      end else begin
        rot <= rot_inc;
      end
      // latch the winner with the deciding point
      if (win_of(nx_self, nx_enemy))
        winner <= (nx_enemy > nx_self);
    end
  end

endmodule

// File: rtl/pinpong_match_ctrl.sv
// Match-level sequencer: serve/rally gating, point
// pauses and game-over handling above the rally engine.
import pinpong_pkg::*;

module pinpong_match_ctrl #(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = 5,
  parameter int SERVE_SWAP  = 2,
  parameter int PAUSE_TICKS = DEF_PAUSE_TICKS,
  parameter int DEUCE_EN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start_btn,
  input  logic               rally_start,
  input  logic               point_self,
  input  logic               point_enemy,
  output logic               serve_en,
  output logic               rally_en,
  output logic               server,
  output logic [SCORE_W-1:0] score_self,
  output logic [SCORE_W-1:0] score_enemy,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_dbg
);

  localparam int PW = (PAUSE_TICKS < 1) ? 1
                    : $clog2(PAUSE_TICKS + 1);

  state_t        state;
  state_t        nstate;
  logic [PW-1:0] pause_cnt;
  logic          btn_low;
  logic          start_edge;
  logic          award;
  logic          clear;
  logic          win;
  logic          srv_nx;

  // btn_low: button was sampled low last cycle
  assign start_edge = start_btn & btn_low;
  assign award      = (state == ST_RALLY) &
                      (point_self ^ point_enemy);
  assign clear      = (state == ST_GAME_OVER) &
                      start_edge;
  assign srv_nx     = clear ? SIDE_SELF : server;
  assign state_dbg  = state;

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:
        if (start_edge) nstate = ST_SERVE_WAIT;
      ST_SERVE_WAIT:
        if (rally_start) nstate = ST_RALLY;
      ST_RALLY:
        if (point_self && point_enemy)
          nstate = ST_SERVE_WAIT;
        else if (point_self || point_enemy)
          nstate = ST_POINT_PAUSE;
      ST_POINT_PAUSE:
        if (pause_cnt == '0)
          nstate = win ? ST_GAME_OVER
                       : ST_SERVE_WAIT;
      ST_GAME_OVER:
        if (start_edge) nstate = ST_SERVE_WAIT;
      default:
        nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
      btn_low   <= 1'b0;
      serve_en  <= 1'b0;
      rally_en  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state   <= nstate;
      btn_low <= ~start_btn;
      if (state == ST_RALLY &&
          nstate == ST_POINT_PAUSE)
        pause_cnt <= PW'(PAUSE_TICKS);
      else if (state == ST_POINT_PAUSE &&
               tick && pause_cnt != '0)
        pause_cnt <= pause_cnt - 1'b1;
      serve_en  <= (nstate == ST_SERVE_WAIT) &&
                   (srv_nx == SIDE_SELF);
      rally_en  <= (nstate == ST_RALLY);
      game_over <= (nstate == ST_GAME_OVER);
    end
  end

  pinpong_score_unit #(
    .WIN_SCORE  (WIN_SCORE),
    .SCORE_W    (SCORE_W),
    .SERVE_SWAP (SERVE_SWAP),
    .DEUCE_EN   (DEUCE_EN)
  ) u_score (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .award       (award),
    .side        (point_enemy),
    .score_self  (score_self),
    .score_enemy (score_enemy),
    .server      (server),
    .winner      (winner),
    .win         (win)
  );

endmodule

// File: tb/tb_pinpong_match_ctrl.sv
// Directed bench for pinpong_match_ctrl with an
// expectation queue checked after every clock.
module tb_pinpong_match_ctrl;

  localparam int WIN  = 11;
  localparam int SMAX = 31;
  localparam int SWAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start_btn;
  logic       rally_start;
  logic       point_self;
  logic       point_enemy;
  logic       serve_en;
  logic       rally_en;
  logic       server;
  logic [4:0] score_self;
  logic [4:0] score_enemy;
  logic       game_over;
  logic       winner;
  logic [2:0] state_dbg;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] ss;
    logic [4:0] se;
    logic       srv;
    logic       sen;
    logic       ren;
    logic       go;
    logic       win;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    vectors;
  int    miscompares;

  int m_st, m_ss, m_se, m_rot;
  bit m_srv, m_win, m_over;

  always #5 clk = ~clk;

  pinpong_match_ctrl #(
    .WIN_SCORE   (11),
    .SCORE_W     (5),
    .SERVE_SWAP  (2),
    .PAUSE_TICKS (4),
    .DEUCE_EN    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start_btn   (start_btn),
    .rally_start (rally_start),
    .point_self  (point_self),
    .point_enemy (point_enemy),
    .serve_en    (serve_en),
    .rally_en    (rally_en),
    .server      (server),
    .score_self  (score_self),
    .score_enemy (score_enemy),
    .game_over   (game_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  function automatic snap_t want();
    snap_t s;
    s.st  = 3'(m_st);
    s.ss  = 5'(m_ss);
    s.se  = 5'(m_se);
    s.srv = m_srv;
    s.sen = (m_st == 1) && !m_srv;
    s.ren = (m_st == 2);
    s.go  = (m_st == 4);
    s.win = m_win;
    return s;
  endfunction

  function automatic snap_t got();
    return {state_dbg, score_self, score_enemy,
            server, serve_en, rally_en,
            game_over, winner};
  endfunction

  task automatic model_clear();
    m_ss   = 0;
    m_se   = 0;
    m_rot  = 0;
    m_srv  = 0;
    m_win  = 0;
    m_over = 0;
  endtask

  task automatic model_award(bit enemy);
    bit deuce;
    deuce = (m_ss >= WIN - 1) && (m_se >= WIN - 1);
    if (enemy) m_se = (m_se == SMAX) ? SMAX : m_se + 1;
    else       m_ss = (m_ss == SMAX) ? SMAX : m_ss + 1;
    if (deuce) begin
      m_srv = !m_srv;
      m_rot = 0;
    end else begin
      m_rot++;
      if (m_rot == SWAP) begin
        m_srv = !m_srv;
        m_rot = 0;
      end
    end
    if ((m_ss >= WIN && m_ss >= m_se + 2) ||
        (m_se >= WIN && m_se >= m_ss + 2) ||
        m_ss == SMAX || m_se == SMAX) begin
      m_over = 1;
      m_win  = (m_se > m_ss);
    end
  endtask

  task automatic compare();
    snap_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (got() === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             t, got(), e);
    end
  endtask

  task automatic step(string tag);
    exp_q.push_back(want());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic play_point(bit enemy, bit inject);
    rally_start = 1'b1;
    m_st = 2;
    step("rally");
    rally_start = 1'b0;
    if (enemy) point_enemy = 1'b1;
    else       point_self  = 1'b1;
    model_award(enemy);
    m_st = 3;
    step("point");
    point_self  = 1'b0;
    point_enemy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      step("pause_tick");
      tick = 1'b0;
      if (i < 3) begin
        if (inject && i == 0) point_self = 1'b1;
        step(inject && i == 0 ? "pause_ignore"
                              : "pause_gap");
        point_self = 1'b0;
      end
    end
    m_st = m_over ? 4 : 1;
    step("pause_exit");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    tick        = 1'b0;
    start_btn   = 1'b0;
    rally_start = 1'b0;
    point_self  = 1'b0;
    point_enemy = 1'b0;
    m_st = 0;
    model_clear();
    @(posedge clk);
    #1;
    step("reset");
    reset = 1'b1;
    step("idle");

    start_btn = 1'b1;
    m_st = 1;
    step("start");
    start_btn = 1'b0;

    play_point(1'b0, 1'b0);
    play_point(1'b0, 1'b0);

    rally_start = 1'b1;
    m_st = 2;
    step("rally_let");
    rally_start = 1'b0;
    point_self  = 1'b1;
    point_enemy = 1'b1;
    m_st = 1;
    step("let");
    point_self  = 1'b0;
    point_enemy = 1'b0;

    point_self = 1'b1;
    step("serve_wait_ignore");
    point_self = 1'b0;

    play_point(1'b1, 1'b1);
    play_point(1'b1, 1'b0);

    while (m_ss < WIN - 1 || m_se < WIN - 1)
      play_point(!(m_ss <= m_se && m_ss < WIN - 1),
                 1'b0);

    play_point(1'b0, 1'b0);
    play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b0);
    play_point(1'b0, 1'b0);

    start_btn = 1'b1;
    model_clear();
    m_st = 1;
    step("restart");
    start_btn = 1'b0;

    play_point(1'b0, 1'b0);
    play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b0);
    play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b0);
    play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b0);
    play_point(1'b0, 1'b0);

    rally_start = 1'b1;
    m_st = 2;
    step("rally_5_3");
    rally_start = 1'b0;

    reset      = 1'b0;
    start_btn  = 1'b1;
    point_self = 1'b1;
    model_clear();
    m_st = 0;
    step("reset_mid_rally");
    point_self = 1'b0;
    reset = 1'b1;
    step("held_btn_idle");
    step("held_btn_idle2");
    start_btn = 1'b0;
    step("btn_released");
    start_btn = 1'b1;
    m_st = 1;
    step("start_after_reset");
    start_btn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pinpong_match_ctrl.md
Name: pinpong_match_ctrl

Overview:
Match-level sequencer that sits above the per-board ping-pong rally engine and its single-wire board link. It decides who serves and when the rally engine may run, collects point events from the rally engine and link, and keeps both scores. It also applies the win and deuce rules and holds the game-over state until the player restarts. One instance runs on each board; all outputs are registered.

Parameters:
WIN_SCORE, 11, points needed to win.
SCORE_W, 5, score counter width; WIN_SCORE must be at most 2^SCORE_W-2.
SERVE_SWAP, 2, points per service turn before the server changes.
PAUSE_TICKS, 4, number of tick pulses to hold between points.
DEUCE_EN, 1, 1 means the winner must lead by 2; 0 means first to WIN_SCORE wins.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  one-clk pulse from the LED-rate clock divider
start_btn  in  1  player button, already synchronised, level signal
rally_start  in  1  pulse: ball launched (local serve hit, or enemy serve received on the link)
point_self  in  1  pulse: the enemy missed or was early; self scores
point_enemy  in  1  pulse: self missed or was early; enemy scores
serve_en  out  1  rally engine may accept the local serve button
rally_en  out  1  rally engine may move the ball
server  out  1  current server: 0 = self, 1 = enemy
score_self  out  SCORE_W  self score
score_enemy  out  SCORE_W  enemy score
game_over  out  1  match finished
winner  out  1  0 = self, 1 = enemy; valid only while game_over is high
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - Both scores are 0; server=0; game_over=0; winner=0; serve_en=0; rally_en=0.
  - The pause counter and the point-in-turn counter are 0.
  - The start_btn edge register is cleared, so a button held through reset does not start a match.
  - Reset wins over every other input in the same cycle.
- start_btn is rising-edge detected internally. Only a 0-to-1 transition counts.
- FSM states:
  - IDLE (0): a start_btn edge moves to SERVE_WAIT.
  - SERVE_WAIT (1):
    - serve_en = (server==0).
    - rally_start moves to RALLY.
    - point pulses are ignored.
  - RALLY (2):
    - rally_en = 1.
    - Exactly one point pulse awards that point and moves to POINT_PAUSE.
    - Both pulses in the same cycle count as a let: no score change, return to SERVE_WAIT with the same server.
    - rally_start is ignored.
  - POINT_PAUSE (3):
    - On entry the pause counter loads PAUSE_TICKS; each tick decrements it.
    - When the counter is 0, move to GAME_OVER if the win condition holds, otherwise to SERVE_WAIT.
    - PAUSE_TICKS=0 exits on the next cycle.
  - GAME_OVER (4):
    - game_over = 1; winner holds.
    - A start_btn edge clears the scores and counters, sets server=0, and moves to SERVE_WAIT.
- Output timing: serve_en, rally_en and game_over are registered decodes of the next state, so they change in the same cycle as state. A point pulse at edge N gives the updated score and rally_en=0 at edge N+1.
- Scoring:
  - A point pulse increments the matching score by 1, saturating at 2^SCORE_W-1.
  - Win condition evaluated with DEUCE_EN=1: a score is at least WIN_SCORE and exceeds the other by at least 2, or either score has reached 2^SCORE_W-1.
  - Win condition evaluated with DEUCE_EN=0: a score equals WIN_SCORE.
  - winner is the side with the higher score. It is latched at the same edge that awards the deciding point.
- Server rotation (evaluated when a point is awarded):
  - Each awarded point increments the point-in-turn counter.
  - When the counter reaches SERVE_SWAP, server toggles and the counter clears.
  - In deuce (DEUCE_EN=1 and both scores at least WIN_SCORE-1), server toggles on every point and the counter stays 0.
  - A let does not advance rotation.
- Reset in the middle of a rally or pause returns to IDLE with everything cleared. No point is awarded for the interrupted rally.

Decomposition:
- Shared package pinpong_pkg holds:
  - state encodings ST_IDLE=0, ST_SERVE_WAIT=1, ST_RALLY=2, ST_POINT_PAUSE=3, ST_GAME_OVER=4.
  - side constants SIDE_SELF=0, SIDE_ENEMY=1.
  - default WIN_SCORE and PAUSE_TICKS values.
- One sub-module: pinpong_score_unit. It holds the two saturating score counters, the win/deuce comparator, the rotation counter and the winner latch. The FSM and the pause counter stay in the top module.

Test Plan:
1. Release reset, pulse start_btn, then rally_start -> state goes 0->1->2; serve_en=1 while in SERVE_WAIT with server=0; rally_en=1 in RALLY; scores 0/0.
2. Award 2 points with point_self, each followed by PAUSE_TICKS=4 ticks and a rally_start -> score_self=2; server toggles to 1 after the 2nd point; serve_en=0 in the next SERVE_WAIT; pause lasts exactly 4 ticks.
3. Drive to 10:10 with DEUCE_EN=1, then award self, enemy, self, self -> server toggles on every point; game_over=1 at 13:11 after the pause; winner=0.
4. Assert point_self and point_enemy together in RALLY -> scores unchanged, state returns to SERVE_WAIT, server and rotation unchanged.
5. Assert point_self during SERVE_WAIT and during POINT_PAUSE -> ignored; score unchanged.
6. Drive reset low mid-RALLY at 5:3, then start again; separately, in GAME_OVER press start_btn -> after reset: IDLE with 0:0, outputs all 0, and a held start_btn does not restart the match; after the GAME_OVER press: scores 0:0, server=0, state=SERVE_WAIT.
